// File: rtl/lockstep_commit_checker.sv
// Lockstep commit checker: buffers golden-core register-write commits and
// compares them in order against the segmented core's WB-stage commits.
// The first divergence, overflow, underflow or stall is latched as a sticky
// error together with the offending PC.
module lockstep_commit_checker #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gold_valid,
  input  logic [XLEN-1:0]        gold_pc,
  input  logic                   gold_we,
  input  logic [4:0]             gold_rd,
  input  logic [XLEN-1:0]        gold_wdata,
  input  logic                   seg_valid,
  input  logic [XLEN-1:0]        seg_pc,
  input  logic                   seg_we,
  input  logic [4:0]             seg_rd,
  input  logic [XLEN-1:0]        seg_wdata,
  output logic                   error,
  output logic [2:0]             error_code,
  output logic [XLEN-1:0]        error_pc,
  output logic [31:0]            commit_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * XLEN + 6;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] CODE_MISMATCH  = 3'd1;
  localparam logic [2:0] CODE_OVERFLOW  = 3'd2;
  localparam logic [2:0] CODE_UNDERFLOW = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR} state_t;

  state_t            r_state;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [TW-1:0]     r_tmo_cnt;
  logic              r_error;
  logic [2:0]        r_error_code;
  logic [XLEN-1:0]   r_error_pc;
  logic [31:0]       r_commit_count;

  logic [EW-1:0]     w_head;
  logic [XLEN-1:0]   w_head_pc;
  logic              w_head_we;
  logic [4:0]        w_head_rd;
  logic [XLEN-1:0]   w_head_wdata;
  logic              w_active;
  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic [XLEN-1:0]   w_ref_pc;
  logic              w_ref_we;
  logic [4:0]        w_ref_rd;
  logic [XLEN-1:0]   w_ref_wdata;
  logic              w_match;
  logic              w_overflow;
  logic              w_underflow;
  logic              w_mismatch;
  logic              w_timeout;
  logic              w_err_any;
  logic [2:0]        w_err_code;
  logic [XLEN-1:0]   w_err_pc;
  logic              w_push;
  logic              w_pop;
  logic              w_commit;

  // Oldest buffered golden commit, unpacked from {pc, we, rd, wdata}.
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_pc    = w_head[EW-1 -: XLEN];
  assign w_head_we    = w_head[XLEN+5];
  assign w_head_rd    = w_head[XLEN+4:XLEN];
  assign w_head_wdata = w_head[XLEN-1:0];

  assign w_active = (r_state != ST_ERR);
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_FULL);
  // With nothing buffered, a same-cycle golden commit is compared directly.
  assign w_bypass = w_empty & gold_valid & seg_valid;

  assign w_ref_pc    = w_empty ? gold_pc    : w_head_pc;
  assign w_ref_we    = w_empty ? gold_we    : w_head_we;
  assign w_ref_rd    = w_empty ? gold_rd    : w_head_rd;
  assign w_ref_wdata = w_empty ? gold_wdata : w_head_wdata;

  // Writes to x0 are architecturally discarded, so rd/wdata only matter for real writes.
  assign w_match = (seg_pc == w_ref_pc) && (seg_we == w_ref_we) &&
                   (!(w_ref_we && (w_ref_rd != 5'd0)) ||
                    ((seg_rd == w_ref_rd) && (seg_wdata == w_ref_wdata)));

  assign w_overflow  = w_active & w_full & gold_valid & ~seg_valid;
  assign w_underflow = w_active & seg_valid & w_empty & ~gold_valid;
  assign w_mismatch  = w_active & seg_valid & (~w_empty | gold_valid) & ~w_match;
  assign w_timeout   = w_active & (r_state == ST_RUN) & ~w_empty & ~seg_valid &
                       (r_tmo_cnt == TMO_LAST);
  assign w_err_any   = w_overflow | w_underflow | w_mismatch | w_timeout;

  // Erroring cycles change nothing except the error record itself.
  assign w_push   = w_active & ~w_err_any & gold_valid & ~w_bypass;
  assign w_pop    = w_active & ~w_err_any & seg_valid & ~w_empty;
  assign w_commit = w_active & ~w_err_any & seg_valid;

  // Pick the highest-priority error and the PC that identifies it.
  always_comb begin
    w_err_code = 3'd0;
    w_err_pc   = '0;
    if (w_overflow) begin
      w_err_code = CODE_OVERFLOW;
      w_err_pc   = gold_pc;
    end else if (w_underflow) begin
      w_err_code = CODE_UNDERFLOW;
      w_err_pc   = seg_pc;
    end else if (w_mismatch) begin
      w_err_code = CODE_MISMATCH;
      w_err_pc   = seg_pc;
    end else if (w_timeout) begin
      w_err_code = CODE_TIMEOUT;
      w_err_pc   = w_head_pc;
    end
  end

  // Golden commit storage; contents need no reset because the pointers do.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= {gold_pc, gold_we, gold_rd, gold_wdata};
    end
  end

  // Control FSM plus pointers, occupancy, stall counter and sticky error record.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_tmo_cnt      <= '0;
      r_error        <= 1'b0;
      r_error_code   <= 3'd0;
      r_error_pc     <= '0;
      r_commit_count <= '0;
    end else if (w_active) begin
      if (w_err_any) begin
        r_state      <= ST_ERR;
        r_error      <= 1'b1;
        r_error_code <= w_err_code;
        r_error_pc   <= w_err_pc;
      end else begin
        if (gold_valid || seg_valid) begin
          r_state <= ST_RUN;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
        if (r_state == ST_RUN) begin
          if (seg_valid || w_empty) begin
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        if (w_commit && (r_commit_count != 32'hFFFF_FFFF)) begin
          r_commit_count <= r_commit_count + 32'd1;
        end
      end
    end
  end

  assign error        = r_error;
  assign error_code   = r_error_code;
  assign error_pc     = r_error_pc;
  assign commit_count = r_commit_count;
  assign fifo_level   = r_level;

endmodule
